// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries instruction word, PC and an operand/control
// payload one stage forward with stall (hold), flush (bubble insertion) and
// NOP normalisation, plus saturating bubble and stall statistics counters.
module pipe_stage_reg #(
    parameter int          PAYLOAD_W        = 128,
    parameter logic [31:0] PC_RESET         = 32'h0000_3000,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int          CNT_W            = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          ir_in,
    input  logic [31:0]          pc_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 out_valid,
    output logic [31:0]          ir_out,
    output logic [31:0]          pc_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Statistics counters stop at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX) begin
            return cnt;
        end
        return cnt + CNT_ONE;
    endfunction

    // PC loaded when a bubble is inserted: either follow the incoming PC so
    // the bubble still carries a meaningful address, or park at PC_RESET.
    function automatic logic [31:0] flush_pc(input logic [31:0] pc);
        return KEEP_PC_ON_FLUSH ? pc : PC_RESET;
    endfunction

    // Stage registers; declaration values make power-up match reset.
    logic                 vld_p1       = 1'b0;
    logic [31:0]          ir_p1        = '0;
    logic [31:0]          pc_p1        = PC_RESET;
    logic [PAYLOAD_W-1:0] payload_p1   = '0;
    logic [CNT_W-1:0]     bubble_cnt_q = '0;
    logic [CNT_W-1:0]     stall_cnt_q  = '0;

    // Stage register update: reset > flush > hold > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            ir_p1      <= '0;
            pc_p1      <= PC_RESET;
            payload_p1 <= '0;
        end else if (flush) begin
            // A flush wins over a stall so the bubble is always inserted.
            vld_p1     <= 1'b0;
            ir_p1      <= '0;
            pc_p1      <= flush_pc(pc_in);
            payload_p1 <= '0;
        end else if (en) begin
            // Invalid slots are normalised to an all-zero NOP, PC still tracks.
            vld_p1     <= in_valid;
            ir_p1      <= in_valid ? ir_in : '0;
            pc_p1      <= pc_in;
            payload_p1 <= in_valid ? payload_in : '0;
        end
    end

    // Bubble/stall statistics, independent of in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (flush) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end else if (!en) begin
            stall_cnt_q  <= sat_inc(stall_cnt_q);
        end
    end

    // ---- stage p1 boundary: every output comes straight from a register ----
    assign out_valid   = vld_p1;
    assign ir_out      = ir_p1;
    assign pc_out      = pc_p1;
    assign payload_out = payload_p1;
    assign bubble_cnt  = bubble_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (default, PC parked at
// PC_RESET on flush, 2-bit counters) share one stimulus stream; each cycle the
// stimulus pushes the hand-computed expected state of one instance and a
// monitor pops and compares on the falling edge.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, en, flush, in_valid;
    logic [31:0]  ir_in, pc_in;
    logic [127:0] payload_in;

    logic         a_v, b_v, c_v;
    logic [31:0]  a_ir, a_pc, b_ir, b_pc, c_ir, c_pc;
    logic [127:0] a_pl, b_pl, c_pl;
    logic [15:0]  a_bc, a_sc, b_bc, b_sc;
    logic [1:0]   c_bc, c_sc;

    typedef struct {
        int           sel;
        string        name;
        logic         v;
        logic [31:0]  ir;
        logic [31:0]  pc;
        logic [127:0] pl;
        logic [15:0]  bc;
        logic [15:0]  sc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] PAT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    pipe_stage_reg dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .ir_in(ir_in), .pc_in(pc_in), .payload_in(payload_in),
        .out_valid(a_v), .ir_out(a_ir), .pc_out(a_pc), .payload_out(a_pl),
        .bubble_cnt(a_bc), .stall_cnt(a_sc)
    );

    pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .ir_in(ir_in), .pc_in(pc_in), .payload_in(payload_in),
        .out_valid(b_v), .ir_out(b_ir), .pc_out(b_pc), .payload_out(b_pl),
        .bubble_cnt(b_bc), .stall_cnt(b_sc)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .ir_in(ir_in), .pc_in(pc_in), .payload_in(payload_in),
        .out_valid(c_v), .ir_out(c_ir), .pc_out(c_pc), .payload_out(c_pl),
        .bubble_cnt(c_bc), .stall_cnt(c_sc)
    );

    // Drive one cycle of stimulus and queue the expected post-edge state.
    task automatic step(input logic r, input logic f, input logic e, input logic iv,
                        input logic [31:0] ir, input logic [31:0] pc, input logic [127:0] pl,
                        input int sel, input string name,
                        input logic ev, input logic [31:0] eir, input logic [31:0] epc,
                        input logic [127:0] epl, input logic [15:0] ebc, input logic [15:0] esc);
        exp_t x;
        reset = r; flush = f; en = e; in_valid = iv;
        ir_in = ir; pc_in = pc; payload_in = pl;
        x.sel = sel; x.name = name; x.v = ev; x.ir = eir; x.pc = epc;
        x.pl = epl; x.bc = ebc; x.sc = esc;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared away from the clock edge.
    initial begin
        exp_t x;
        logic         gv;
        logic [31:0]  gir, gpc;
        logic [127:0] gpl;
        logic [15:0]  gbc, gsc;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                case (x.sel)
                    0: begin gv = a_v; gir = a_ir; gpc = a_pc; gpl = a_pl; gbc = a_bc; gsc = a_sc; end
                    1: begin gv = b_v; gir = b_ir; gpc = b_pc; gpl = b_pl; gbc = b_bc; gsc = b_sc; end
                    default: begin
                        gv = c_v; gir = c_ir; gpc = c_pc; gpl = c_pl;
                        gbc = {14'b0, c_bc}; gsc = {14'b0, c_sc};
                    end
                endcase
                checks++;
                if (gv !== x.v || gir !== x.ir || gpc !== x.pc || gpl !== x.pl ||
                    gbc !== x.bc || gsc !== x.sc) begin
                    errors++;
                    $display("FAIL %s: got v=%0b ir=%h pc=%h pl=%h bc=%0d sc=%0d required v=%0b ir=%h pc=%h pl=%h bc=%0d sc=%0d",
                             x.name, gv, gir, gpc, gpl, gbc, gsc,
                             x.v, x.ir, x.pc, x.pl, x.bc, x.sc);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with flush/stall active: reset must win.
        step(1, 1, 0, 1, 32'hFFFF_FFFF, 32'h1234, ONES, 0, "reset",      0, 0, 32'h3000, 0, 0, 0);
        step(0, 0, 1, 1, 32'h2408_0005, 32'h3000, ONES, 0, "load",       1, 32'h2408_0005, 32'h3000, ONES, 0, 0);
        // Three stall cycles with changing inputs: outputs frozen.
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h4000, PAT,  0, "hold1",      1, 32'h2408_0005, 32'h3000, ONES, 0, 1);
        step(0, 0, 0, 0, 32'h0BAD_F00D, 32'h4004, 0,    0, "hold2",      1, 32'h2408_0005, 32'h3000, ONES, 0, 2);
        step(0, 0, 0, 1, 32'h1111_2222, 32'h4008, PAT,  0, "hold3",      1, 32'h2408_0005, 32'h3000, ONES, 0, 3);
        // Flush during stall: bubble, PC follows pc_in (A) or parks at PC_RESET (B).
        step(0, 1, 0, 1, 32'h5555_AAAA, 32'h3008, ONES, 0, "flush_keep", 0, 0, 32'h3008, 0, 1, 3);
        step(0, 1, 0, 1, 32'h5555_AAAA, 32'h3008, ONES, 1, "flush_park", 0, 0, 32'h3000, 0, 2, 3);
        // Invalid load normalised to NOP but PC tracks.
        step(0, 0, 1, 0, 32'hFFFF_FFFF, 32'h300C, ONES, 0, "nop_norm",   0, 0, 32'h300C, 0, 2, 3);
        step(0, 0, 1, 1, 32'h1234_5678, 32'h3010, PAT,  0, "load2",      1, 32'h1234_5678, 32'h3010, PAT, 2, 3);
        step(0, 1, 1, 1, 32'h8765_4321, 32'h3014, PAT,  0, "flush_en1",  0, 0, 32'h3014, 0, 3, 3);
        step(0, 0, 0, 1, 32'h8765_4321, 32'h3018, PAT,  0, "hold4",      0, 0, 32'h3014, 0, 3, 4);
        // Reset mid-stall with flush asserted.
        step(1, 1, 0, 1, 32'h9999_9999, 32'h301C, ONES, 0, "reset_stall", 0, 0, 32'h3000, 0, 0, 0);
        // 2-bit counter saturation (instance C).
        step(0, 1, 1, 1, 32'h7777_7777, 32'h3020, ONES, 2, "bsat1",      0, 0, 32'h3020, 0, 1, 0);
        step(0, 1, 1, 1, 32'h7777_7777, 32'h3020, ONES, 2, "bsat2",      0, 0, 32'h3020, 0, 2, 0);
        step(0, 1, 1, 1, 32'h7777_7777, 32'h3020, ONES, 2, "bsat3",      0, 0, 32'h3020, 0, 3, 0);
        step(0, 1, 1, 1, 32'h7777_7777, 32'h3020, ONES, 2, "bsat4",      0, 0, 32'h3020, 0, 3, 0);
        step(0, 1, 1, 1, 32'h7777_7777, 32'h3020, ONES, 2, "bsat5",      0, 0, 32'h3020, 0, 3, 0);
        step(0, 0, 0, 1, 32'h6666_6666, 32'h5000, PAT,  2, "ssat1",      0, 0, 32'h3020, 0, 3, 1);
        step(0, 0, 0, 0, 32'h6666_6666, 32'h5004, PAT,  2, "ssat2",      0, 0, 32'h3020, 0, 3, 2);
        step(0, 0, 0, 1, 32'h6666_6666, 32'h5008, PAT,  2, "ssat3",      0, 0, 32'h3020, 0, 3, 3);
        step(0, 0, 0, 0, 32'h6666_6666, 32'h500C, PAT,  2, "ssat4",      0, 0, 32'h3020, 0, 3, 3);
        // Instance A after all that: 5 bubbles and 4 stalls since the last reset.
        step(0, 0, 1, 1, 32'hAAAA_5555, 32'h3024, PAT,  0, "load3",      1, 32'hAAAA_5555, 32'h3024, PAT, 5, 4);
        en = 1'b1; flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
